// File: rtl/nor_share_pkg.sv
// Shared types and helpers for the time-shared NOR evaluation arbiter.
package nor_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nor_unit.sv
// Combinational W-bit bitwise NOR; the only piece mapped onto the gate library.
module nor_unit #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y_c
);

  assign y_c = ~(a | b);

endmodule

// File: rtl/nor_share_arb.sv
// Round-robin scheduler sharing one NOR unit among NREQ requesters:
// grant, latch operands, evaluate, then pulse done for one cycle.
module nor_share_arb
  import nor_share_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned IDXW = idx_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_bus,
  input  logic [NREQ*W-1:0] b_bus,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      y,
  output logic [IDXW-1:0]   gnt_idx,
  output logic              busy
);

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  state_t          state;
  state_t          state_n;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] sel_idx;
  logic [IDXW-1:0] cand;
  logic            sel_vld;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    nor_y_c;

  // Wrap base+off into 0..NREQ-1 without relying on a power-of-two NREQ.
  function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDXW'(s);
  endfunction

  // First requesting index at or above rr_ptr, wrapping around.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = wrap_idx(rr_ptr, k);
      if (!sel_vld && req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel_idx == IDXW'(i)) begin
        sel_a = a_bus[i*W +: W];
        sel_b = b_bus[i*W +: W];
      end
    end
  end

  nor_unit #(.W(W)) u_nor (
    .a   (op_a),
    .b   (op_b),
    .y_c (nor_y_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sel_vld) state_n = EVAL;
      EVAL:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs, advanced in step with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      gnt_idx <= '0;
      op_a    <= '0;
      op_b    <= '0;
      y       <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            gnt_idx <= sel_idx;
            busy    <= 1'b1;
          end
        end
        EVAL: begin
          y    <= nor_y_c;
          done <= ONE_HOT0 << gnt_idx;
        end
        DONE: begin
          busy   <= 1'b0;
          rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_share_arb.sv
// Directed bench for nor_share_arb with a done-pulse scoreboard.
module tb_nor_share_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;
  logic [3:0]  done;
  logic [3:0]  y;
  logic [1:0]  gnt_idx;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] done;
    logic [3:0] y;
    logic [1:0] gnt;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  nor_share_arb #(.NREQ(4), .W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a_bus   (a_bus),
    .b_bus   (b_bus),
    .done    (done),
    .y       (y),
    .gnt_idx (gnt_idx),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [3:0] nor4(input logic [3:0] a, input logic [3:0] b);
    return ~(a | b);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ops(input int idx, input logic [3:0] a, input logic [3:0] b);
    a_bus[idx*4 +: 4] = a;
    b_bus[idx*4 +: 4] = b;
  endtask

  task automatic expect_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                           input int when);
    exp_t e;
    e.done = 4'b0001 << idx;
    e.y    = nor4(a, b);
    e.gnt  = 2'(idx);
    e.cyc  = when;
    sb.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'(0));
  endtask

  // One isolated operation from a single requester.
  task automatic do_op(input int idx, input logic [3:0] a, input logic [3:0] b);
    set_ops(idx, a, b);
    req = 4'b0001 << idx;
    expect_op(idx, a, b, cyc + 2);
    tick();
    check("op_busy", 32'(busy), 32'(1));
    check("op_gnt", 32'(gnt_idx), 32'(idx));
    req = '0;
    tick();
    tick();
    check_idle("op_end");
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done !== 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        check("done", 32'(done), 32'(e.done));
        check("y", 32'(y), 32'(e.y));
        check("done_gnt", 32'(gnt_idx), 32'(e.gnt));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int t0;
    rst   = 1'b1;
    req   = 4'b1111;
    a_bus = 16'h96C3;
    b_bus = 16'h5A21;

    // Held reset with all requests high.
    repeat (3) begin
      tick();
      check("rst_done", 32'(done), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_y", 32'(y), 32'(0));
      check("rst_gnt", 32'(gnt_idx), 32'(0));
    end

    // Contention: grants rotate 0,1,2,3,0 every 3 cycles.
    rst = 1'b0;
    t0  = cyc;
    for (int k = 0; k < 5; k++)
      expect_op(k % 4, a_bus[(k%4)*4 +: 4], b_bus[(k%4)*4 +: 4], t0 + 2 + 3*k);
    tick();
    check("first_gnt", 32'(gnt_idx), 32'(0));
    check("first_busy", 32'(busy), 32'(1));
    repeat (14) tick();
    req = '0;
    tick();
    check_idle("contention_end");

    // Single request from requester 2.
    do_op(2, 4'b0101, 4'b0011);
    check("single_y", 32'(y), 32'(4'b1000));

    // Truth table on requester 0.
    do_op(0, 4'b0000, 4'b0000);
    do_op(0, 4'b0000, 4'b1111);
    do_op(0, 4'b1111, 4'b0000);
    do_op(0, 4'b1111, 4'b1111);

    // Operands change during EVAL; latched values must be used.
    set_ops(1, 4'b0000, 4'b0000);
    req = 4'b0010;
    expect_op(1, 4'b0000, 4'b0000, cyc + 2);
    tick();
    set_ops(1, 4'b1111, 4'b1111);
    req = '0;
    tick();
    tick();
    check_idle("opchg_end");
    check("opchg_y_hold", 32'(y), 32'(4'b1111));

    // Reset in EVAL aborts the operation without a done pulse.
    set_ops(2, 4'b0011, 4'b0100);
    req = 4'b0100;
    tick();
    check("abort_busy_eval", 32'(busy), 32'(1));
    check("abort_gnt_eval", 32'(gnt_idx), 32'(2));
    rst = 1'b1;
    req = '0;
    tick();
    check("abort_done", 32'(done), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_y", 32'(y), 32'(0));
    check("abort_gnt", 32'(gnt_idx), 32'(0));
    rst = 1'b0;
    tick();
    check_idle("abort_after");

    // rr_ptr restarted at 0: requesters 0 and 3 both asking, 0 wins first.
    set_ops(0, 4'b1010, 4'b0001);
    set_ops(3, 4'b0110, 4'b0000);
    req = 4'b1001;
    expect_op(0, 4'b1010, 4'b0001, cyc + 2);
    expect_op(3, 4'b0110, 4'b0000, cyc + 5);
    repeat (4) tick();
    req = '0;
    repeat (3) tick();
    check_idle("restart_end");

    // Requester 3 alone after the pointer wrapped back to 0.
    do_op(3, 4'b0001, 4'b0010);

    check("final_sb_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
